// File: rtl/div_pkg.sv
// div_pkg: shared widths, iteration count and FSM state codes for the sequential divider
package div_pkg;
    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int PREM_W     = 5;
    localparam int ITERATIONS = 8;
    localparam int CNT_W      = $clog2(ITERATIONS);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/div_trial_sub5.sv
// div_trial_sub5: 5-bit trial subtraction of the divisor; no-borrow is the quotient bit
module div_trial_sub5
    import div_pkg::*;
(
    input  logic [PREM_W-1:0]    t,
    input  logic [DIVISOR_W-1:0] d,
    output logic [PREM_W-1:0]    diff,
    output logic                 q_bit
);
    logic [PREM_W:0] full;
    assign full  = {1'b0, t} - {2'b00, d};
    assign diff  = full[PREM_W-1:0];
    assign q_bit = ~full[PREM_W];
endmodule

// File: rtl/divider_8b_4b_seq.sv
// divider_8b_4b_seq: restoring 8b/4b divider, one quotient bit per clock behind valid/ready
module divider_8b_4b_seq
    import div_pkg::*;
#(
    parameter int W_DIVIDEND = DIVIDEND_W,
    parameter int W_DIVISOR  = DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W_DIVIDEND-1:0] dividend,
    input  logic [W_DIVISOR-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W_DIVIDEND-1:0] quotient,
    output logic [W_DIVISOR-1:0]  remainder,
    output logic                  div_by_zero
);
    logic [1:0]            state;
    logic [W_DIVIDEND-1:0] q_sh;
    logic [W_DIVISOR-1:0]  d_r;
    logic [PREM_W-1:0]     r_acc;
    logic [PREM_W-1:0]     t;
    logic [PREM_W-1:0]     diff;
    logic [CNT_W-1:0]      cnt;
    logic                  dbz_r;
    logic                  q_bit;
    logic                  unused_r_msb;

    // the top remainder bit only ever carries divide-by-zero overflow and is shifted out
    assign unused_r_msb = r_acc[PREM_W-1];
    assign t            = {r_acc[W_DIVISOR-1:0], q_sh[W_DIVIDEND-1]};
    assign in_ready     = state == ST_IDLE;
    assign out_valid    = state == ST_DONE;
    assign quotient     = q_sh;
    assign remainder    = r_acc[W_DIVISOR-1:0];
    assign div_by_zero  = dbz_r;

    div_trial_sub5 u_sub (
        .t     (t),
        .d     (d_r),
        .diff  (diff),
        .q_bit (q_bit)
    );

    // handshake FSM plus one restoring-division step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q_sh  <= '0;
            d_r   <= '0;
            r_acc <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    q_sh  <= dividend;
                    d_r   <= divisor;
                    r_acc <= '0;
                    cnt   <= CNT_W'(ITERATIONS - 1);
                    dbz_r <= divisor == '0;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    r_acc <= q_bit ? diff : t;
                    q_sh  <= {q_sh[W_DIVIDEND-2:0], q_bit};
                    if (cnt == '0) state <= ST_DONE;
                    else cnt <= cnt - 1'b1;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_8b_4b_seq.sv
// tb_divider_8b_4b_seq: scoreboard bench with directed, exhaustive and multiplier round-trip traffic
module tb_divider_8b_4b_seq;
    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = 0;
    int   hold = 0;
    logic was_valid = 1'b0;
    logic [7:0] sq;
    logic [3:0] sr;
    logic       sz;
    exp_t sb[$];

    divider_8b_4b_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // present one operand pair at the next idle slot and record its expected result
    task automatic send(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r, input logic z);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            in_valid = 1'b0;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic send_model(input int a, input int b);
        if (b == 0) send(8'(a), 4'(b), 8'hFF, 4'(a % 16), 1'b1);
        else send(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && sb.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    // monitor: drives out_ready, checks latency, stability under stall and popped results
    always @(negedge clk) begin
        if (!rst_n) begin
            was_valid = 1'b0;
            hold = 0;
        end else begin
            hold = out_valid ? hold + 1 : 0;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : (hold > 5);
            if (out_valid && !was_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc, sb[0].acc + 8);
                sq = quotient; sr = remainder; sz = div_by_zero;
            end else if (out_valid) begin
                chk("hold_quotient", quotient, sq);
                chk("hold_remainder", remainder, sr);
                chk("hold_dbz", div_by_zero, sz);
                chk("hold_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                if (e.b != 0) begin
                    chk("invariant_sum", quotient * e.b + remainder, e.a);
                    chk("invariant_rem_lt_div", remainder < e.b, 1);
                end
            end
            was_valid = out_valid;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        send(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        send(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        send(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
        send(8'd0, 4'd15, 8'd0, 4'd0, 1'b0);
        send(8'hA7, 4'd0, 8'hFF, 4'd7, 1'b1);
        wait_idle();
        mode = 2;
        send(8'd123, 4'd11, 8'd11, 4'd2, 1'b0);
        wait_idle();
        mode = 0;
        send(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
        wait_idle();
        send(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
        wait_idle();
        mode = 1;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                send_model(a, b);
        for (int x = 0; x < 16; x++)
            for (int y = 1; y < 16; y++)
                send(8'(x * y), 4'(y), 8'(x), 4'd0, 1'b0);
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
